// File: rtl/hpdl_text_writer.sv
// Writer side of a 16-character HPDL-1414 display buffer: takes an ASCII stream, folds it into the
// 64-glyph set, runs control codes and drives single-cycle writes into the display memory.
module hpdl_text_writer #(
  parameter int SCROLL         = 1,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [7:0] char_data,
  input  logic       char_valid,
  output logic       char_ready,
  output logic       w_en,
  output logic [3:0] w_addr,
  output logic [7:0] w_data,
  output logic [4:0] cursor,
  output logic       busy
);

  localparam logic [6:0] SPACE   = 7'h20;
  localparam logic [7:0] CHAR_BS = 8'h08;
  localparam logic [7:0] CHAR_FF = 8'h0C;
  localparam logic [7:0] CHAR_CR = 8'h0D;

  typedef enum logic [2:0] {ST_INIT, ST_IDLE, ST_WRITE, ST_CLEAR, ST_SCROLL} state_t;

  state_t     state_q, state_d;
  logic       ready_q, ready_d;
  logic       w_en_q, w_en_d;
  logic [3:0] w_addr_q, w_addr_d;
  logic [6:0] w_data_q, w_data_d;
  logic [4:0] cursor_q, cursor_d;
  logic       busy_q, busy_d;
  logic [6:0] glyph_q, glyph_d;
  logic [6:0] shadow_q [16];

  logic       accept;
  logic       is_ctrl;
  logic [6:0] glyph;
  logic [3:0] nxt_addr;

  // Lower case folds onto upper case; anything above 0x7F shows as '?'.
  function automatic logic [6:0] fold_glyph(input logic [7:0] c);
    if (c[7])
      return 7'h3F;
    else if (c[6:5] == 2'b11)
      return c[6:0] - 7'h20;
    else
      return c[6:0];
  endfunction

  assign accept   = char_valid && ready_q;
  assign is_ctrl  = (char_data < 8'h20);
  assign glyph    = fold_glyph(char_data);
  assign nxt_addr = w_addr_q + 4'd1;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= ST_INIT;
      ready_q  <= 1'b0;
      w_en_q   <= 1'b0;
      w_addr_q <= 4'd0;
      w_data_q <= 7'd0;
      cursor_q <= 5'd0;
      busy_q   <= 1'b0;
      glyph_q  <= SPACE;
      for (int i = 0; i < 16; i++) shadow_q[i] <= SPACE;
    end else begin
      state_q  <= state_d;
      ready_q  <= ready_d;
      w_en_q   <= w_en_d;
      w_addr_q <= w_addr_d;
      w_data_q <= w_data_d;
      cursor_q <= cursor_d;
      busy_q   <= busy_d;
      glyph_q  <= glyph_d;
      if (w_en_d) shadow_q[w_addr_d] <= w_data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_INIT:  state_d = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;
      ST_IDLE: begin
        if (accept) begin
          if (char_data == CHAR_FF)
            state_d = ST_CLEAR;
          else if (!is_ctrl && cursor_q == 5'd16 && SCROLL != 0)
            state_d = ST_SCROLL;
          else
            state_d = ST_WRITE;
        end
      end
      ST_WRITE: state_d = ST_IDLE;
      ST_CLEAR, ST_SCROLL: begin
        if (w_addr_q == 4'hF) state_d = ST_IDLE;
      end
      default:  state_d = ST_INIT;
    endcase
  end

  // Every output is registered: this block computes the value each output flop takes at the next edge.
  always_comb begin
    ready_d  = 1'b0;
    w_en_d   = 1'b0;
    w_addr_d = w_addr_q;
    w_data_d = w_data_q;
    cursor_d = cursor_q;
    busy_d   = 1'b0;
    glyph_d  = glyph_q;
    case (state_q)
      ST_INIT: begin
        if (CLEAR_ON_RESET != 0) begin
          w_en_d   = 1'b1;
          w_addr_d = 4'd0;
          w_data_d = SPACE;
          busy_d   = 1'b1;
        end else begin
          ready_d = 1'b1;
        end
      end
      ST_IDLE: begin
        if (!accept) begin
          ready_d = 1'b1;
        end else if (char_data == CHAR_FF) begin
          w_en_d   = 1'b1;
          w_addr_d = 4'd0;
          w_data_d = SPACE;
          busy_d   = 1'b1;
        end else if (char_data == CHAR_CR) begin
          cursor_d = 5'd0;
        end else if (char_data == CHAR_BS) begin
          cursor_d = (cursor_q == 5'd0) ? 5'd0 : cursor_q - 5'd1;
        end else if (!is_ctrl) begin
          w_en_d = 1'b1;
          if (cursor_q != 5'd16) begin
            w_addr_d = cursor_q[3:0];
            w_data_d = glyph;
            cursor_d = cursor_q + 5'd1;
          end else if (SCROLL != 0) begin
            w_addr_d = 4'd0;
            w_data_d = shadow_q[1];
            glyph_d  = glyph;
            busy_d   = 1'b1;
          end else begin
            w_addr_d = 4'd0;
            w_data_d = glyph;
            cursor_d = 5'd1;
          end
        end
      end
      ST_WRITE: ready_d = 1'b1;
      ST_CLEAR: begin
        if (w_addr_q == 4'hF) begin
          ready_d  = 1'b1;
          cursor_d = 5'd0;
        end else begin
          w_en_d   = 1'b1;
          w_addr_d = nxt_addr;
          w_data_d = SPACE;
          busy_d   = 1'b1;
        end
      end
      ST_SCROLL: begin
        // Shadow is read one slot ahead of the slot being rewritten, so the shift needs no copy.
        if (w_addr_q == 4'hF) begin
          ready_d = 1'b1;
        end else begin
          w_en_d   = 1'b1;
          w_addr_d = nxt_addr;
          w_data_d = (nxt_addr == 4'hF) ? glyph_q : shadow_q[nxt_addr + 4'd1];
          busy_d   = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign char_ready = ready_q;
  assign w_en       = w_en_q;
  assign w_addr     = w_addr_q;
  assign w_data     = {1'b0, w_data_q};
  assign cursor     = cursor_q;
  assign busy       = busy_q;

endmodule
